// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Bundles the fetch-stage signals: the redirect input, the
//               Icache request/response channel and the IF/ID queue head.
//               master = fetch unit side, slave = environment side
//               (flow control, Icache and decode).
// Signals     : redirect_valid_i/redirect_pc_i   redirect from flow control
//               icache_req_o/icache_pc_o         fetch request and its PC
//               icache_ready_i                   Icache accepts the request
//               icache_rvalid_i/icache_rdata_i   block response
//               out_valid_o/out_pc_o/out_inst_o/out_mask_o  queue head
//               out_ready_i                      downstream consumes the head
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if #(
  parameter int FETCH_W = 2
);
  logic                   redirect_valid_i;
  logic [31:0]            redirect_pc_i;
  logic                   icache_req_o;
  logic [31:0]            icache_pc_o;
  logic                   icache_ready_i;
  logic                   icache_rvalid_i;
  logic [32*FETCH_W-1:0]  icache_rdata_i;
  logic                   out_valid_o;
  logic [31:0]            out_pc_o;
  logic [32*FETCH_W-1:0]  out_inst_o;
  logic [FETCH_W-1:0]     out_mask_o;
  logic                   out_ready_i;

  modport master (
    input  redirect_valid_i, redirect_pc_i,
    output icache_req_o, icache_pc_o,
    input  icache_ready_i, icache_rvalid_i, icache_rdata_i,
    output out_valid_o, out_pc_o, out_inst_o, out_mask_o,
    input  out_ready_i
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i,
    input  icache_req_o, icache_pc_o,
    output icache_ready_i, icache_rvalid_i, icache_rdata_i,
    input  out_valid_o, out_pc_o, out_inst_o, out_mask_o,
    output out_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Fetch stage. Issues block-aligned fetch requests to the
//               Icache (one outstanding), buffers returned blocks in a
//               FQ_DEPTH-entry queue towards IF/ID, and handles redirects by
//               flushing the queue and dropping stale responses.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               bus    - if_fetch_unit_if.master (redirect, Icache channel,
//                        queue head towards decode)
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          FETCH_W  = 2,
  parameter int          FQ_DEPTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  if_fetch_unit_if.master  bus
);

  localparam int c_BLK_BYTES = 4 * FETCH_W;
  localparam int c_OFF_W     = $clog2(FETCH_W);
  localparam int c_PTR_W     = $clog2(FQ_DEPTH);
  localparam int c_CNT_W     = c_PTR_W + 1;
  localparam int c_DATA_W    = 32 * FETCH_W;

  localparam logic [31:0]        c_BLK_INC  = 32'(c_BLK_BYTES);
  localparam logic [31:0]        c_BLK_MASK = ~(32'(c_BLK_BYTES) - 32'd1);
  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FQ_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_fetch_pc;
  logic [31:0]         w_fetch_pc_nxt;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic [31:0]         r_q_pc   [FQ_DEPTH];
  logic [c_DATA_W-1:0] r_q_inst [FQ_DEPTH];
  logic [FETCH_W-1:0]  r_q_mask [FQ_DEPTH];

  logic               w_req;
  logic               w_accept;
  logic               w_redirect;
  logic               w_flush;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic [31:0]        w_base;
  logic [FETCH_W-1:0] w_mask;

  // The request is gated by the registered count only; the slot taken by a
  // request stays reserved through WAIT, so its response can never overflow.
  assign w_req      = (r_state == S_REQ) && (r_count < c_FULL);
  assign w_accept   = w_req && bus.icache_ready_i;
  assign w_redirect = bus.redirect_valid_i;
  assign w_flush    = w_redirect && (r_state != S_START);
  assign w_push     = (r_state == S_WAIT) && bus.icache_rvalid_i && !w_redirect;
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && bus.out_ready_i;
  assign w_base     = r_fetch_pc & c_BLK_MASK;

  // Slots below the word offset of the fetch PC belong to the previous
  // block position and are marked invalid (e.g. after a mid-block redirect).
  generate
    if (FETCH_W == 1) begin : g_mask_single
      assign w_mask = 1'b1;
    end else begin : g_mask_multi
      logic [c_OFF_W-1:0] w_off;
      assign w_off = r_fetch_pc[c_OFF_W+1:2];
      for (genvar k = 0; k < FETCH_W; k++) begin : g_bit
        assign w_mask[k] = (c_OFF_W'(k) >= w_off);
      end
    end
  endgenerate

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      S_START: begin
        w_state_nxt = S_REQ;
        if (w_redirect) w_fetch_pc_nxt = bus.redirect_pc_i;
      end
      S_REQ: begin
        if (w_redirect) begin
          w_fetch_pc_nxt = bus.redirect_pc_i;
          // A request accepted in the redirect cycle is already stale.
          w_state_nxt    = w_accept ? S_DRAIN : S_REQ;
        end else if (w_accept) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_fetch_pc_nxt = bus.redirect_pc_i;
          w_state_nxt    = bus.icache_rvalid_i ? S_REQ : S_DRAIN;
        end else if (bus.icache_rvalid_i) begin
          w_fetch_pc_nxt = w_base + c_BLK_INC;
          w_state_nxt    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (w_redirect) w_fetch_pc_nxt = bus.redirect_pc_i;
        if (bus.icache_rvalid_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_START;
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
        else if (!w_push && w_pop) r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // Queue storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= w_base;
      r_q_inst[r_wr_ptr] <= bus.icache_rdata_i;
      r_q_mask[r_wr_ptr] <= w_mask;
    end
  end

  assign bus.icache_req_o = w_req;
  assign bus.icache_pc_o  = r_fetch_pc;
  assign bus.out_valid_o  = w_valid;
  assign bus.out_pc_o     = w_valid ? r_q_pc[r_rd_ptr]   : '0;
  assign bus.out_inst_o   = w_valid ? r_q_inst[r_rd_ptr] : '0;
  assign bus.out_mask_o   = w_valid ? r_q_mask[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit
//               (FETCH_W=2, FQ_DEPTH=4, RESET_PC=0). Expected queue entries
//               are pushed when a response is driven and popped when the
//               head is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
    logic [1:0]  mask;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  if_fetch_unit_if #(.FETCH_W(2)) bus ();

  if_fetch_unit #(
    .RESET_PC (32'h0),
    .FETCH_W  (2),
    .FQ_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] blk_data(input logic [31:0] base);
    return {base ^ 32'hC0DE_0004, base ^ 32'hBEEF_0000};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.icache_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 64'(bus.icache_req_o), 64'd1);
  endtask

  // Accept the request at pc, answer it the following cycle.
  task automatic fetch_one(input logic [31:0] pc, input string tag);
    exp_t e;
    logic [31:0] base;
    wait_req(tag);
    check({tag, "_pc"}, 64'(bus.icache_pc_o), 64'(pc));
    base = pc & ~32'd7;
    bus.icache_ready_i = 1'b1;
    tick();
    bus.icache_ready_i  = 1'b0;
    bus.icache_rvalid_i = 1'b1;
    bus.icache_rdata_i  = blk_data(base);
    e.pc   = base;
    e.inst = blk_data(base);
    e.mask = pc[2] ? 2'b10 : 2'b11;
    exp_q.push_back(e);
    tick();
    bus.icache_rvalid_i = 1'b0;
    bus.icache_rdata_i  = '0;
  endtask

  task automatic consume(input string tag);
    exp_t e;
    check({tag, "_vld"}, 64'(bus.out_valid_o), 64'd1);
    check({tag, "_sb"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_hpc"},   64'(bus.out_pc_o),   64'(e.pc));
      check({tag, "_hinst"}, bus.out_inst_o,       e.inst);
      check({tag, "_hmask"}, 64'(bus.out_mask_o), 64'(e.mask));
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = pc;
    tick();
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.icache_ready_i   = 1'b0;
    bus.icache_rvalid_i  = 1'b0;
    bus.icache_rdata_i   = '0;
    bus.out_ready_i      = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_req",   64'(bus.icache_req_o), 64'd0);
    check("rst_pc",    64'(bus.icache_pc_o),  64'h0);
    check("rst_vld",   64'(bus.out_valid_o),  64'd0);
    check("rst_opc",   64'(bus.out_pc_o),     64'h0);
    check("rst_oinst", bus.out_inst_o,         64'h0);
    check("rst_omask", 64'(bus.out_mask_o),   64'h0);

    // Release: START cycle has no request, the next cycle requests pc 0
    rst_n = 1'b1;
    check("start_req", 64'(bus.icache_req_o), 64'd0);
    tick();
    check("first_req", 64'(bus.icache_req_o), 64'd1);
    fetch_one(32'h0, "f0");
    check("f0_next_pc", 64'(bus.icache_pc_o), 64'h8);
    consume("c0");

    // Redirect in REQ to a mid-block target
    redirect(32'h104);
    fetch_one(32'h104, "f104");
    check("f104_next_pc", 64'(bus.icache_pc_o), 64'h108);
    consume("c104");

    // Fill the queue with four blocks while downstream stalls
    redirect(32'h0);
    fetch_one(32'h0,  "fill0");
    fetch_one(32'h8,  "fill1");
    fetch_one(32'h10, "fill2");
    fetch_one(32'h18, "fill3");
    check("full_req_a", 64'(bus.icache_req_o), 64'd0);
    bus.icache_ready_i = 1'b1;
    tick();
    bus.icache_ready_i = 1'b0;
    check("full_req_b", 64'(bus.icache_req_o), 64'd0);
    check("full_pc",    64'(bus.icache_pc_o),  64'h20);
    consume("cfull");
    check("after_pop_req", 64'(bus.icache_req_o), 64'd1);
    check("after_pop_pc",  64'(bus.icache_pc_o),  64'h20);

    // Full queue + redirect + pop in the same cycle
    fetch_one(32'h20, "refill");
    check("refull_req", 64'(bus.icache_req_o), 64'd0);
    bus.out_ready_i = 1'b1;
    redirect(32'h200);
    bus.out_ready_i = 1'b0;
    exp_q.delete();
    check("flush_vld",   64'(bus.out_valid_o),  64'd0);
    check("flush_opc",   64'(bus.out_pc_o),     64'h0);
    check("flush_oinst", bus.out_inst_o,         64'h0);
    check("flush_req",   64'(bus.icache_req_o), 64'd1);
    check("flush_pc",    64'(bus.icache_pc_o),  64'h200);
    fetch_one(32'h200, "f200");
    consume("c200");
    check("c200_empty", 64'(bus.out_valid_o), 64'd0);

    // Redirect in WAIT, stale response three cycles later
    wait_req("w208");
    check("w208_pc", 64'(bus.icache_pc_o), 64'h208);
    bus.icache_ready_i = 1'b1;
    tick();
    bus.icache_ready_i = 1'b0;
    redirect(32'h40);
    check("drain_req", 64'(bus.icache_req_o), 64'd0);
    check("drain_pc",  64'(bus.icache_pc_o),  64'h40);
    tick();
    tick();
    bus.icache_rvalid_i = 1'b1;
    bus.icache_rdata_i  = blk_data(32'h208);
    tick();
    bus.icache_rvalid_i = 1'b0;
    bus.icache_rdata_i  = '0;
    check("stale_vld", 64'(bus.out_valid_o),  64'd0);
    check("stale_req", 64'(bus.icache_req_o), 64'd1);
    fetch_one(32'h40, "f40");
    consume("c40");

    // Redirect in the same cycle a request is accepted -> drain
    wait_req("w48");
    bus.icache_ready_i = 1'b1;
    redirect(32'h80);
    bus.icache_ready_i = 1'b0;
    check("acc_redir_req", 64'(bus.icache_req_o), 64'd0);
    check("acc_redir_pc",  64'(bus.icache_pc_o),  64'h80);
    bus.icache_rvalid_i = 1'b1;
    bus.icache_rdata_i  = blk_data(32'h48);
    tick();
    bus.icache_rvalid_i = 1'b0;
    check("acc_redir_vld", 64'(bus.out_valid_o),  64'd0);
    check("acc_redir_req2", 64'(bus.icache_req_o), 64'd1);

    // Redirect together with the response -> discard, straight to REQ
    wait_req("w80");
    bus.icache_ready_i = 1'b1;
    tick();
    bus.icache_ready_i  = 1'b0;
    bus.icache_rvalid_i = 1'b1;
    bus.icache_rdata_i  = blk_data(32'h80);
    redirect(32'hFFFF_FFFC);
    bus.icache_rvalid_i = 1'b0;
    bus.icache_rdata_i  = '0;
    check("rv_redir_vld", 64'(bus.out_valid_o),  64'd0);
    check("rv_redir_req", 64'(bus.icache_req_o), 64'd1);
    fetch_one(32'hFFFF_FFFC, "fwrap");
    check("wrap_pc", 64'(bus.icache_pc_o), 64'h0);
    consume("cwrap");

    // Reset asserted during WAIT with a non-empty queue
    fetch_one(32'h0, "pre_rst");
    wait_req("w8");
    bus.icache_ready_i = 1'b1;
    tick();
    bus.icache_ready_i = 1'b0;
    check("pre_rst_vld", 64'(bus.out_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_req", 64'(bus.icache_req_o), 64'd0);
    check("mid_rst_pc",  64'(bus.icache_pc_o),  64'h0);
    check("mid_rst_vld", 64'(bus.out_valid_o),  64'd0);
    check("mid_rst_opc", 64'(bus.out_pc_o),     64'h0);
    bus.icache_rvalid_i = 1'b1;
    bus.icache_rdata_i  = blk_data(32'h8);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    bus.icache_rvalid_i = 1'b0;
    bus.icache_rdata_i  = '0;
    check("late_rv_vld", 64'(bus.out_valid_o),  64'd0);
    check("late_rv_req", 64'(bus.icache_req_o), 64'd1);
    check("late_rv_pc",  64'(bus.icache_pc_o),  64'h0);
    fetch_one(32'h0, "post_rst");
    consume("cpost");
    check("end_empty", 64'(bus.out_valid_o), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
